// File: rtl/pe_scan_seq_if.sv
// Handshake bundle for the set-bit iterator: the requester drives start/data_in/out_ready,
// and the iterator returns the index stream and scan status.
interface pe_scan_seq_if #(
    parameter int WIDTH  = 32,
    parameter int CODE_W = $clog2(WIDTH)
);
    logic              start;
    logic [WIDTH-1:0]  data_in;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic              out_valid;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              zero_flag;
    logic [CODE_W:0]   count;

    modport master (
        output start, data_in, out_ready,
        input  out_code, out_valid, out_last, busy, done, zero_flag, count
    );

    modport slave (
        input  start, data_in, out_ready,
        output out_code, out_valid, out_last, busy, done, zero_flag, count
    );
endinterface

// File: rtl/pe_scan_seq.sv
// Sequential priority encoder: captures a request vector and emits each set-bit index, one per handshake.
// First index one cycle after start; out_ready low holds out_code/out_valid; start is ignored while busy.
module pe_scan_seq #(
    parameter int WIDTH     = 32,
    parameter int CODE_W    = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clock,
    input  logic          clear,
    pe_scan_seq_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  pending_q, pending_d;
    logic [CODE_W:0]   count_q, count_d;
    logic              zero_q, zero_d;

    logic [CODE_W-1:0] enc_code;
    logic [WIDTH-1:0]  sel_mask;
    logic              single_bit;
    logic              in_scan;

    // Later loop iterations win, so the scan direction picks the priority end.
    always_comb begin
        enc_code = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (pending_q[i]) enc_code = CODE_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (pending_q[i]) enc_code = CODE_W'(i);
            end
        end
    end

    assign sel_mask   = WIDTH'(1) << enc_code;
    assign single_bit = (pending_q != '0) && ((pending_q & (pending_q - WIDTH'(1))) == '0);
    assign in_scan    = (state_q == ST_SCAN);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        zero_d    = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    pending_d = bus.data_in;
                    count_d   = '0;
                    zero_d    = (bus.data_in == '0);
                    state_d   = (bus.data_in != '0) ? ST_SCAN : ST_DONE;
                end
            end
            ST_SCAN: begin
                if (bus.out_ready) begin
                    pending_d = pending_q & ~sel_mask;
                    count_d   = count_q + 1'b1;
                    if (single_bit) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            count_q   <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            zero_q    <= zero_d;
        end
    end

    assign bus.out_valid = in_scan;
    assign bus.out_code  = in_scan ? enc_code : '0;
    assign bus.out_last  = in_scan && single_bit;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.zero_flag = zero_q;
    assign bus.count     = count_q;
endmodule
